// File: rtl/dcache_ctrl.sv
// Controller FSM for a direct-mapped write-back data cache (tag-array responder, memory sequencer).
// Latency: hits complete in the request cycle; misses stall for WRITE_BACK + ALLOCATE wait + fill + UPDATE.
// Backpressure: stall holds the core while a miss is serviced; memory handshakes via level requests and a mem_ready pulse.
module dcache_ctrl #(
  parameter int IDX    = 12,
  parameter int TAG    = 9,
  parameter int OFF    = 4,
  parameter int ADDR_W = TAG + IDX + OFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              hit,
  input  logic              dirty,
  input  logic [TAG-1:0]    victim_tag,
  input  logic              mem_ready,
  output logic              stall,
  output logic [IDX-1:0]    index,
  output logic [TAG-1:0]    tag_in,
  output logic              replace_tag,
  output logic              valid_in,
  output logic              dirty_in,
  output logic              data_we,
  output logic              fill_we,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr
);

  typedef enum logic [1:0] {IDLE, WRITE_BACK, ALLOCATE, UPDATE} state_t;

  state_t               state;
  logic [TAG+IDX-1:0]   miss_addr;  // {tag, index} of the line being serviced
  logic [TAG-1:0]       wb_tag;     // tag of the dirty victim being written back

  logic                 cpu_req;
  logic [TAG-1:0]       cpu_tag;
  logic [IDX-1:0]       cpu_idx;
  logic                 unused_offset;

  assign cpu_req       = cpu_read | cpu_write;
  assign cpu_tag       = cpu_addr[ADDR_W-1 -: TAG];
  assign cpu_idx       = cpu_addr[OFF +: IDX];
  // Byte offset only selects a word inside the line; the controller works on whole lines.
  assign unused_offset = ^cpu_addr[OFF-1:0];

  // State sequencing and capture of the miss line and victim tag at detection time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      miss_addr <= '0;
      wb_tag    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req && !hit) begin
            miss_addr <= cpu_addr[ADDR_W-1:OFF];
            wb_tag    <= victim_tag;
            state     <= dirty ? WRITE_BACK : ALLOCATE;
          end
        end
        WRITE_BACK: if (mem_ready) state <= ALLOCATE;
        ALLOCATE:   if (mem_ready) state <= UPDATE;
        UPDATE:     state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // Output decode; while rst is high every strobe and request is forced low.
  always_comb begin
    stall       = 1'b0;
    replace_tag = 1'b0;
    valid_in    = 1'b0;
    dirty_in    = 1'b0;
    data_we     = 1'b0;
    fill_we     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    // Once a miss is latched the core address is no longer trusted for indexing.
    index       = (state == IDLE) ? cpu_idx : miss_addr[IDX-1:0];
    tag_in      = (state == IDLE) ? cpu_tag : miss_addr[TAG+IDX-1:IDX];
    if (!rst) begin
      case (state)
        IDLE: begin
          if (cpu_req && hit && cpu_write) begin
            data_we     = 1'b1;
            replace_tag = 1'b1;
            valid_in    = 1'b1;
            dirty_in    = 1'b1;
          end else if (cpu_req && !hit) begin
            stall = 1'b1;
          end
        end
        WRITE_BACK: begin
          stall     = 1'b1;
          mem_write = 1'b1;
          mem_addr  = {wb_tag, index, {OFF{1'b0}}};
        end
        ALLOCATE: begin
          stall    = 1'b1;
          mem_read = 1'b1;
          mem_addr = {tag_in, index, {OFF{1'b0}}};
          if (mem_ready) begin
            fill_we     = 1'b1;
            replace_tag = 1'b1;
            valid_in    = 1'b1;
          end
        end
        UPDATE: stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: table of single-cycle IDLE vectors plus hand-written miss sequences.
// Latency: inputs driven on negedge, outputs sampled 1 time unit later (well before the next posedge).
// Backpressure: memory responses are modelled by directed mem_ready pulses.
module tb_dcache_ctrl;

  localparam int IDX    = 12;
  localparam int TAG    = 9;
  localparam int OFF    = 4;
  localparam int ADDR_W = TAG + IDX + OFF;

  // ctrl bit constants: {stall, replace_tag, data_we, fill_we, mem_read, mem_write, valid_in, dirty_in}
  localparam logic [7:0] C_IDLE  = 8'b0000_0000;
  localparam logic [7:0] C_WHIT  = 8'b0110_0011;
  localparam logic [7:0] C_STALL = 8'b1000_0000;
  localparam logic [7:0] C_AWAIT = 8'b1000_1000;
  localparam logic [7:0] C_AFILL = 8'b1101_1010;
  localparam logic [7:0] C_WB    = 8'b1000_0100;

  logic              clk, rst;
  logic              cpu_read, cpu_write, hit, dirty, mem_ready;
  logic [ADDR_W-1:0] cpu_addr, mem_addr;
  logic [TAG-1:0]    victim_tag, tag_in;
  logic [IDX-1:0]    index;
  logic              stall, replace_tag, valid_in, dirty_in, data_we, fill_we, mem_read, mem_write;
  logic [7:0]        ctrl;

  int n_vec  = 0;
  int n_miss = 0;
  int stall_cnt;

  assign ctrl = {stall, replace_tag, data_we, fill_we, mem_read, mem_write, valid_in, dirty_in};

  dcache_ctrl #(.IDX(IDX), .TAG(TAG), .OFF(OFF), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .hit(hit), .dirty(dirty), .victim_tag(victim_tag), .mem_ready(mem_ready),
    .stall(stall), .index(index), .tag_in(tag_in),
    .replace_tag(replace_tag), .valid_in(valid_in), .dirty_in(dirty_in),
    .data_we(data_we), .fill_we(fill_we),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [ADDR_W-1:0] mk(input logic [TAG-1:0] t, input logic [IDX-1:0] i,
                                           input logic [OFF-1:0] o);
    return {t, i, o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [7:0] c, input logic [ADDR_W-1:0] ma,
                         input logic [IDX-1:0] ix, input logic [TAG-1:0] tg);
    chk({nm, ".ctrl"}, 32'(ctrl), 32'(c));
    chk({nm, ".mem_addr"}, 32'(mem_addr), 32'(ma));
    chk({nm, ".index"}, 32'(index), 32'(ix));
    chk({nm, ".tag_in"}, 32'(tag_in), 32'(tg));
  endtask

  // Move to the next negedge and settle combinational outputs.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  typedef struct {
    logic              rd, wr;
    logic [ADDR_W-1:0] addr;
    logic              h, d, mrdy;
    logic [7:0]        exp_ctrl;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Each vector keeps the FSM in IDLE, so they can be applied back to back.
    vecs[0] = '{1'b0, 1'b0, mk(9'h0AB, 12'h456, 4'h3), 1'b0, 1'b0, 1'b1, C_IDLE};
    vecs[1] = '{1'b1, 1'b0, mk(9'h1FF, 12'hFFF, 4'hF), 1'b1, 1'b0, 1'b0, C_IDLE};
    vecs[2] = '{1'b0, 1'b1, mk(9'h055, 12'h123, 4'h0), 1'b1, 1'b0, 1'b0, C_WHIT};
    vecs[3] = '{1'b1, 1'b1, mk(9'h000, 12'h000, 4'h7), 1'b1, 1'b0, 1'b0, C_WHIT};
    vecs[4] = '{1'b0, 1'b0, mk(9'h100, 12'h800, 4'h1), 1'b0, 1'b1, 1'b0, C_IDLE};
    vecs[5] = '{1'b1, 1'b0, mk(9'h0F0, 12'h00F, 4'h8), 1'b1, 1'b1, 1'b1, C_IDLE};
    vecs[6] = '{1'b0, 1'b1, mk(9'h1FF, 12'hFFF, 4'hF), 1'b1, 1'b1, 1'b1, C_WHIT};

    rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0;
    hit = 1'b0; dirty = 1'b0; victim_tag = '0; mem_ready = 1'b0;

    // Reset state, including a pending miss that must not stall while rst is high.
    next_cyc(); #1;
    chk_all("reset_idle", C_IDLE, '0, '0, '0);
    cpu_read = 1'b1; cpu_addr = mk(9'h1A0, 12'h010, 4'h0); #1;
    chk_all("reset_req", C_IDLE, '0, 12'h010, 9'h1A0);
    cpu_read = 1'b0;
    next_cyc(); rst = 1'b0;

    // Table-driven IDLE vectors.
    for (int i = 0; i < 7; i++) begin
      next_cyc();
      cpu_read = vecs[i].rd; cpu_write = vecs[i].wr; cpu_addr = vecs[i].addr;
      hit = vecs[i].h; dirty = vecs[i].d; mem_ready = vecs[i].mrdy;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp_ctrl, '0,
              vecs[i].addr[OFF +: IDX], vecs[i].addr[ADDR_W-1 -: TAG]);
    end
    next_cyc();
    cpu_read = 1'b0; cpu_write = 1'b0; hit = 1'b0; dirty = 1'b0; mem_ready = 1'b0;

    // Clean read miss, mem_ready on the 3rd ALLOCATE cycle: 5 stall cycles.
    stall_cnt = 0;
    next_cyc();
    cpu_read = 1'b1; cpu_addr = mk(9'h1A0, 12'h010, 4'h0); victim_tag = 9'h033; #1;
    chk_all("crm_detect", C_STALL, '0, 12'h010, 9'h1A0); stall_cnt += int'(stall);
    for (int c = 0; c < 2; c++) begin
      next_cyc(); #1;
      chk_all($sformatf("crm_wait%0d", c), C_AWAIT, mk(9'h1A0, 12'h010, 4'h0), 12'h010, 9'h1A0);
      stall_cnt += int'(stall);
    end
    next_cyc(); mem_ready = 1'b1; #1;
    chk_all("crm_fill", C_AFILL, mk(9'h1A0, 12'h010, 4'h0), 12'h010, 9'h1A0);
    stall_cnt += int'(stall);
    next_cyc(); mem_ready = 1'b0; #1;
    chk_all("crm_update", C_STALL, '0, 12'h010, 9'h1A0); stall_cnt += int'(stall);
    next_cyc(); hit = 1'b1; #1;
    chk_all("crm_rehit", C_IDLE, '0, 12'h010, 9'h1A0); stall_cnt += int'(stall);
    chk("crm_stall_cycles", 32'(stall_cnt), 32'd5);
    next_cyc(); cpu_read = 1'b0; hit = 1'b0;

    // Dirty write miss: write-back of victim 0x0FF, then allocate 0x0AA, then write hit.
    next_cyc();
    cpu_write = 1'b1; cpu_addr = mk(9'h0AA, 12'h2B7, 4'h4); dirty = 1'b1; victim_tag = 9'h0FF; #1;
    chk_all("dwm_detect", C_STALL, '0, 12'h2B7, 9'h0AA);
    next_cyc(); victim_tag = 9'h011; dirty = 1'b0; #1;
    chk_all("dwm_wb0", C_WB, mk(9'h0FF, 12'h2B7, 4'h0), 12'h2B7, 9'h0AA);
    next_cyc(); mem_ready = 1'b1; #1;
    chk_all("dwm_wb1", C_WB, mk(9'h0FF, 12'h2B7, 4'h0), 12'h2B7, 9'h0AA);
    next_cyc(); mem_ready = 1'b0; #1;
    chk_all("dwm_alloc", C_AWAIT, mk(9'h0AA, 12'h2B7, 4'h0), 12'h2B7, 9'h0AA);
    next_cyc(); mem_ready = 1'b1; #1;
    chk_all("dwm_fill", C_AFILL, mk(9'h0AA, 12'h2B7, 4'h0), 12'h2B7, 9'h0AA);
    next_cyc(); mem_ready = 1'b0; #1;
    chk_all("dwm_update", C_STALL, '0, 12'h2B7, 9'h0AA);
    next_cyc(); hit = 1'b1; #1;
    chk_all("dwm_whit", C_WHIT, '0, 12'h2B7, 9'h0AA);
    next_cyc(); cpu_write = 1'b0; hit = 1'b0;

    // Address perturbation during ALLOCATE: latched miss line wins.
    next_cyc();
    cpu_read = 1'b1; cpu_addr = mk(9'h077, 12'h3C4, 4'h0); #1;
    chk_all("pert_detect", C_STALL, '0, 12'h3C4, 9'h077);
    next_cyc(); cpu_addr = mk(9'h155, 12'hABC, 4'h5); #1;
    chk_all("pert_alloc", C_AWAIT, mk(9'h077, 12'h3C4, 4'h0), 12'h3C4, 9'h077);
    next_cyc(); mem_ready = 1'b1; #1;
    chk_all("pert_fill", C_AFILL, mk(9'h077, 12'h3C4, 4'h0), 12'h3C4, 9'h077);
    next_cyc(); mem_ready = 1'b0; cpu_addr = mk(9'h077, 12'h3C4, 4'h0); #1;
    chk_all("pert_update", C_STALL, '0, 12'h3C4, 9'h077);
    next_cyc(); hit = 1'b1; #1;
    chk_all("pert_rehit", C_IDLE, '0, 12'h3C4, 9'h077);
    next_cyc(); cpu_read = 1'b0; hit = 1'b0;

    // Reset while waiting in ALLOCATE.
    next_cyc();
    cpu_read = 1'b1; cpu_addr = mk(9'h101, 12'h0F0, 4'h0); #1;
    chk_all("rst_detect", C_STALL, '0, 12'h0F0, 9'h101);
    next_cyc(); #1;
    chk_all("rst_alloc", C_AWAIT, mk(9'h101, 12'h0F0, 4'h0), 12'h0F0, 9'h101);
    rst = 1'b1; #1;
    chk_all("rst_async", C_IDLE, '0, 12'h0F0, 9'h101);
    next_cyc(); mem_ready = 1'b1; #1;
    chk_all("rst_held_mrdy", C_IDLE, '0, 12'h0F0, 9'h101);
    next_cyc(); rst = 1'b0; cpu_read = 1'b0; #1;
    chk_all("rst_late_mrdy", C_IDLE, '0, 12'h0F0, 9'h101);
    next_cyc(); mem_ready = 1'b0; cpu_read = 1'b1; hit = 1'b1; #1;
    chk_all("rst_after_hit", C_IDLE, '0, 12'h0F0, 9'h101);
    next_cyc(); cpu_read = 1'b0; hit = 1'b0; #1;
    chk_all("rst_final_idle", C_IDLE, '0, 12'h0F0, 9'h101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
